inst_fetch_queue: RTL and testbench

//  Instruction fetch front end feeding decode: generates sequential PCs, fetches from instruction

---
 rtl/inst_fetch_queue.sv | 93 +++++++++
 tb/tb_inst_fetch_queue.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential-PC instruction fetch with req/ack memory port,
// a DEPTH-entry {pc, word} FIFO to decode, and redirect flush/restart.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] inst_pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];
  logic          push, pop;

  assign imem_req_o    = state_q != IDLE;
  assign imem_addr_o   = state_q == DROP ? drop_addr_q : fetch_pc_q;
  assign inst_valid_o  = count_q != '0;
  assign instruction_o = word_q[head_q];
  assign inst_pc_o     = pc_q[head_q];

  // A redirect wins over any push or pop in the same cycle.
  assign push    = state_q == REQ && imem_ack_i && !redirect_valid_i;
  assign pop     = inst_valid_o && inst_ready_i && !redirect_valid_i;
  assign count_d = redirect_valid_i ? '0 : count_q + CW'(push) - CW'(pop);
  assign head_d  = redirect_valid_i ? '0 : head_q + AW'(pop);
  assign tail_d  = redirect_valid_i ? '0 : tail_q + AW'(push);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      IDLE: state_d = (redirect_valid_i || count_q != FULL) ? REQ : IDLE;
      REQ: begin
        if (redirect_valid_i) begin
          state_d     = imem_ack_i ? REQ : DROP;
          drop_addr_d = fetch_pc_q;
        end else if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = count_d != FULL ? REQ : IDLE;
        end
      end
      default: state_d = imem_ack_i ? REQ : DROP;
    endcase
    if (redirect_valid_i) fetch_pc_d = redirect_pc_i & ~32'h3;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      if (push) begin
        pc_q[tail_q]   <= fetch_pc_q;
        word_q[tail_q] <= imem_rdata_i;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed sequence for inst_fetch_queue with a zero/ multi-wait
// memory whose word for address a is a ^ 32'h1357_9BDF.
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ack ? wd(imem_addr) : 32'h0;

  inst_fetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .instruction_o(instruction), .inst_pc_o(inst_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_pc"}, inst_pc, pc);
      chk({tag, "_instr"}, instruction, wd(pc));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk_fetch("rst", 1'b0, 32'h0);
    chk_head("rst", 1'b0, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    // 1: streaming, one instruction per cycle
    imem_ack = 1'b1;
    inst_ready = 1'b1;
    step();
    chk_fetch("t1_e1", 1'b1, 32'h0);
    chk_head("t1_e1", 1'b0, 32'h0);
    for (int n = 2; n <= 5; n++) begin
      step();
      chk_fetch("t1_stream", 1'b1, 32'(4 * (n - 1)));
      chk_head("t1_stream", 1'b1, 32'(4 * (n - 2)));
    end
    // 2: fill with decode stalled, then drain
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    chk_fetch("t2_redir", 1'b1, 32'h0);
    chk_head("t2_redir", 1'b0, 32'h0);
    step(); chk_fetch("t2_p1", 1'b1, 32'h4); chk_head("t2_p1", 1'b1, 32'h0);
    step(); chk_fetch("t2_p2", 1'b1, 32'h8); chk_head("t2_p2", 1'b1, 32'h0);
    step(); chk_fetch("t2_p3", 1'b1, 32'hC); chk_head("t2_p3", 1'b1, 32'h0);
    step(); chk("t2_full_req", {31'b0, imem_req}, 32'h0); chk_head("t2_full", 1'b1, 32'h0);
    step(); chk("t2_hold_req", {31'b0, imem_req}, 32'h0); chk_head("t2_hold", 1'b1, 32'h0);
    inst_ready = 1'b1;
    step(); chk("t2_d1_req", {31'b0, imem_req}, 32'h0); chk_head("t2_d1", 1'b1, 32'h4);
    step(); chk_fetch("t2_d2", 1'b1, 32'h10); chk_head("t2_d2", 1'b1, 32'h8);
    step(); chk_fetch("t2_d3", 1'b1, 32'h14); chk_head("t2_d3", 1'b1, 32'hC);
    step(); chk_fetch("t2_d4", 1'b1, 32'h18); chk_head("t2_d4", 1'b1, 32'h10);
    // 3: three wait states
    imem_ack = 1'b0;
    step(); chk_fetch("t3_w1", 1'b1, 32'h18); chk_head("t3_w1", 1'b1, 32'h14);
    step(); chk_fetch("t3_w2", 1'b1, 32'h18); chk_head("t3_w2", 1'b0, 32'h0);
    step(); chk_fetch("t3_w3", 1'b1, 32'h18); chk_head("t3_w3", 1'b0, 32'h0);
    imem_ack = 1'b1;
    step(); chk_fetch("t3_ack", 1'b1, 32'h1C); chk_head("t3_ack", 1'b1, 32'h18);
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    step(); chk_fetch("t3_stall", 1'b1, 32'h1C); chk_head("t3_stall", 1'b1, 32'h18);
    // 4: redirect while a request is pending -> DROP
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk_fetch("t4_drop", 1'b1, 32'h1C); chk_head("t4_drop", 1'b0, 32'h0);
    step(); chk_fetch("t4_drop_hold", 1'b1, 32'h1C); chk_head("t4_drop_hold", 1'b0, 32'h0);
    imem_ack = 1'b1;
    step(); chk_fetch("t4_restart", 1'b1, 32'h100); chk_head("t4_discard", 1'b0, 32'h0);
    step(); chk_fetch("t4_next", 1'b1, 32'h104); chk_head("t4_push", 1'b1, 32'h100);
    // 5: redirect coincident with ack and pop, unaligned target
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step(); chk_fetch("t5_redir", 1'b1, 32'h200); chk_head("t5_flush", 1'b0, 32'h0);
    // 6: PC wrap, then async reset mid-request
    redirect_pc = 32'hFFFF_FFFC;
    step(); chk_fetch("t6_redir", 1'b1, 32'hFFFF_FFFC); chk_head("t6_redir", 1'b0, 32'h0);
    redirect_valid = 1'b0;
    step(); chk_fetch("t6_wrap", 1'b1, 32'h0); chk_head("t6_wrap", 1'b1, 32'hFFFF_FFFC);
    step(); chk_fetch("t6_after", 1'b1, 32'h4); chk_head("t6_after", 1'b1, 32'h0);
    imem_ack = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_fetch("t6_rst", 1'b0, 32'h0);
    chk("t6_rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("t6_rst_instr", instruction, 32'h0);
    chk("t6_rst_pc", inst_pc, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
